// File: rtl/traffic_pkg.sv
// Shared types and timing helpers for the intersection phase scheduler.
package traffic_pkg;

    typedef enum logic [2:0] {
        MAIN_G   = 3'd0,
        MAIN_Y   = 3'd1,
        SIDE_G   = 3'd2,
        SIDE_Y   = 3'd3,
        PED_WALK = 3'd4,
        AR_M     = 3'd5,
        AR_S     = 3'd6
    } state_t;

    typedef struct packed {
        logic main_red;
        logic main_yellow;
        logic main_green;
        logic side_red;
        logic side_yellow;
        logic side_green;
        logic walk;
    } lamp_t;

    function automatic int max_time(int a, int b, int c, int d, int e);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (e > m) m = e;
        return m;
    endfunction

    function automatic int phase_time(state_t s, int main_g, int side_g, int yellow,
                                      int walk_t, int all_red);
        int t;
        case (s)
            MAIN_G:         t = main_g;
            MAIN_Y, SIDE_Y: t = yellow;
            SIDE_G:         t = side_g;
            PED_WALK:       t = walk_t;
            default:        t = all_red;
        endcase
        return t;
    endfunction

    // Any state that is not green/yellow for an approach shows red on it.
    function automatic lamp_t lamp_decode(state_t s);
        lamp_t l;
        l.main_green  = (s == MAIN_G);
        l.main_yellow = (s == MAIN_Y);
        l.main_red    = !(l.main_green || l.main_yellow);
        l.side_green  = (s == SIDE_G);
        l.side_yellow = (s == SIDE_Y);
        l.side_red    = !(l.side_green || l.side_yellow);
        l.walk        = (s == PED_WALK);
        return l;
    endfunction

endpackage

// File: rtl/intersection_phase_scheduler_if.sv
// Control/status bundle between the scheduler and its surroundings.
interface intersection_phase_scheduler_if #(parameter int W = 4);
    logic         en;
    logic         sec_tick;
    logic         side_car;
    logic         ped_req;
    logic         ped_ack;
    logic         main_red, main_yellow, main_green;
    logic         side_red, side_yellow, side_green;
    logic         walk;
    logic [W-1:0] cnt_out;

    modport master (
        output en, sec_tick, side_car, ped_req,
        input  ped_ack, main_red, main_yellow, main_green,
               side_red, side_yellow, side_green, walk, cnt_out
    );

    modport slave (
        input  en, sec_tick, side_car, ped_req,
        output ped_ack, main_red, main_yellow, main_green,
               side_red, side_yellow, side_green, walk, cnt_out
    );
endinterface

// File: rtl/phase_down_counter.sv
// Loadable seconds down-counter; expire flags the tick that would take it past 1.
module phase_down_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         expire
);
    assign expire = en && tick && (count == W'(1));

    always_ff @(posedge clk) begin
        if (load)
            count <= load_val;
        else if (en && tick)
            count <= count - W'(1);
    end
endmodule

// File: rtl/intersection_phase_scheduler.sv
// Two-approach intersection sequencer with pedestrian crossing and one shared phase counter.
// Define ALL_RED_CLEAR_EN to insert an all-red clearance phase after each yellow.
module intersection_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int MAIN_GREEN_TIME = 15,
    parameter int SIDE_GREEN_TIME = 10,
    parameter int YELLOW_TIME     = 3,
    parameter int WALK_TIME       = 8,
    parameter int ALL_RED_TIME    = 2,
    parameter int pCount_Width    = $clog2(max_time(MAIN_GREEN_TIME, SIDE_GREEN_TIME,
                                           YELLOW_TIME, WALK_TIME, ALL_RED_TIME) + 1)
) (
    input  logic clk,
    input  logic rstb,
    intersection_phase_scheduler_if.slave bus
);
    state_t                  state, next_state;
    lamp_t                   lamps;
    logic                    ped_pend, ped_pend_eff, ped_ack;
    logic                    expire;
    logic [pCount_Width-1:0] count, load_val;

    // A request arriving on the deciding edge still wins the crossing.
    assign ped_pend_eff = ped_pend | bus.ped_req;

    always_comb begin
        next_state = state;
        case (state)
            MAIN_G:   next_state = (bus.side_car || ped_pend_eff) ? MAIN_Y : MAIN_G;
`ifdef ALL_RED_CLEAR_EN
            MAIN_Y:   next_state = AR_M;
            AR_M:     next_state = ped_pend_eff ? PED_WALK : SIDE_G;
            SIDE_Y:   next_state = AR_S;
            AR_S:     next_state = MAIN_G;
`else
            MAIN_Y:   next_state = ped_pend_eff ? PED_WALK : SIDE_G;
            SIDE_Y:   next_state = MAIN_G;
`endif
            SIDE_G:   next_state = SIDE_Y;
            PED_WALK: next_state = bus.side_car ? SIDE_G : MAIN_G;
            default:  next_state = MAIN_G;
        endcase
    end

    assign load_val = rstb ? pCount_Width'(MAIN_GREEN_TIME)
                           : pCount_Width'(phase_time(next_state, MAIN_GREEN_TIME,
                                 SIDE_GREEN_TIME, YELLOW_TIME, WALK_TIME, ALL_RED_TIME));

    phase_down_counter #(.W(pCount_Width)) u_cnt (
        .clk      (clk),
        .load     (rstb | expire),
        .load_val (load_val),
        .tick     (bus.sec_tick),
        .en       (bus.en),
        .count    (count),
        .expire   (expire)
    );

    always_ff @(posedge clk) begin
        if (rstb) begin
            state    <= MAIN_G;
            lamps    <= lamp_decode(MAIN_G);
            ped_pend <= 1'b0;
            ped_ack  <= 1'b0;
        end else begin
            ped_ack <= expire && (next_state == PED_WALK);
            if (expire) begin
                state <= next_state;
                lamps <= lamp_decode(next_state);
            end
            // Requests during the walk itself are absorbed, not queued for another walk.
            if (expire && next_state == PED_WALK)
                ped_pend <= 1'b0;
            else if (bus.ped_req && state != PED_WALK)
                ped_pend <= 1'b1;
        end
    end

    assign bus.ped_ack     = ped_ack;
    assign bus.main_red    = lamps.main_red;
    assign bus.main_yellow = lamps.main_yellow;
    assign bus.main_green  = lamps.main_green;
    assign bus.side_red    = lamps.side_red;
    assign bus.side_yellow = lamps.side_yellow;
    assign bus.side_green  = lamps.side_green;
    assign bus.walk        = lamps.walk;
    assign bus.cnt_out     = count;
endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Randomized + directed bench for intersection_phase_scheduler against a phase/seconds model.
module tb_intersection_phase_scheduler;
    import traffic_pkg::*;

    localparam int MG = 4, SG = 3, YT = 2, WT = 3, ART = 1;
    localparam int W  = $clog2(max_time(MG, SG, YT, WT, ART) + 1);
`ifdef ALL_RED_CLEAR_EN
    localparam int ARX = ART;
`else
    localparam int ARX = 0;
`endif
    // Expected lamp words {mr,my,mg,sr,sy,sg,walk}
    localparam logic [6:0] L_MG = 7'b0011000, L_MY = 7'b0101000, L_SG = 7'b1000010,
                           L_SY = 7'b1000100, L_WK = 7'b1001001, L_AR = 7'b1001000;

    logic clk = 1'b0;
    logic rstb = 1'b1;
    always #5 clk = ~clk;

    intersection_phase_scheduler_if #(.W(W)) bus();

    intersection_phase_scheduler #(
        .MAIN_GREEN_TIME(MG), .SIDE_GREEN_TIME(SG), .YELLOW_TIME(YT),
        .WALK_TIME(WT), .ALL_RED_TIME(ART)
    ) dut (
        .clk  (clk),
        .rstb (rstb),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lamps_now();
        return int'({bus.main_red, bus.main_yellow, bus.main_green,
                     bus.side_red, bus.side_yellow, bus.side_green, bus.walk});
    endfunction

    // ---------------- behavioural model ----------------
    typedef enum int {P_MG, P_MY, P_SG, P_SY, P_WK, P_ARM, P_ARS} ph_e;
    ph_e m_ph = P_MG;
    int  m_rem = 0;
    bit  m_pend = 0, m_ack = 0, mvalid = 0;

    function automatic int dur(ph_e p);
        case (p)
            P_MG: return MG;
            P_SG: return SG;
            P_MY, P_SY: return YT;
            P_WK: return WT;
            default: return ART;
        endcase
    endfunction

    function automatic ph_e after(ph_e p, bit side, bit preq);
        case (p)
            P_MG: return (side || preq) ? P_MY : P_MG;
`ifdef ALL_RED_CLEAR_EN
            P_MY: return P_ARM;
            P_SY: return P_ARS;
`else
            P_MY: return preq ? P_WK : P_SG;
            P_SY: return P_MG;
`endif
            P_ARM: return preq ? P_WK : P_SG;
            P_ARS: return P_MG;
            P_SG: return P_SY;
            default: return side ? P_SG : P_MG;
        endcase
    endfunction

    function automatic int lamp_of(ph_e p);
        case (p)
            P_MG: return int'(L_MG);
            P_MY: return int'(L_MY);
            P_SG: return int'(L_SG);
            P_SY: return int'(L_SY);
            P_WK: return int'(L_WK);
            default: return int'(L_AR);
        endcase
    endfunction

    always @(posedge clk) begin
        ph_e old;
        bit preq;
        if (rstb) begin
            m_ph = P_MG; m_rem = MG; m_pend = 0; m_ack = 0; mvalid = 1;
        end else begin
            old  = m_ph;
            preq = m_pend | bus.ped_req;
            m_ack = 0;
            if (bus.en && bus.sec_tick) begin
                if (m_rem > 1) m_rem--;
                else begin
                    m_ph  = after(old, bus.side_car, preq);
                    m_rem = dur(m_ph);
                end
            end
            if (m_ph == P_WK && old != P_WK) begin
                m_pend = 0; m_ack = 1;
            end else if (bus.ped_req && old != P_WK) begin
                m_pend = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (mvalid) begin
            chk("cnt_out", int'(bus.cnt_out), m_rem);
            chk("lamps", lamps_now(), lamp_of(m_ph));
            chk("ped_ack", int'(bus.ped_ack), int'(m_ack));
            chk("both_nonred", int'(!bus.main_red && !bus.side_red), 0);
            chk("walk_not_red", int'(bus.walk && !(bus.main_red && bus.side_red)), 0);
            chk("main_onehot", $countones({bus.main_red, bus.main_yellow, bus.main_green}), 1);
            chk("side_onehot", $countones({bus.side_red, bus.side_yellow, bus.side_green}), 1);
        end
    end

    // ---------------- stimulus helpers ----------------
    int pc = 0;

    task automatic step(output bit ticked);
        bus.sec_tick = (pc % 4 == 3);
        ticked = bus.sec_tick;
        pc++;
        @(posedge clk); #1;
        bus.sec_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        int k = 0;
        int guard = 0;
        bit t;
        while (k < n && guard < n * 4 + 8) begin
            step(t);
            if (t) k++;
            guard++;
        end
        if (k < n) chk("tick_budget", k, n);
    endtask

    task automatic do_reset();
        rstb = 1'b1;
        bus.sec_tick = 1'b0;
        @(posedge clk); #1;
        rstb = 1'b0;
        pc = 0;
    endtask

    task automatic chk_state(input string name, input logic [6:0] l, input int c);
        chk({name, "_lamps"}, lamps_now(), int'(l));
        chk({name, "_cnt"}, int'(bus.cnt_out), c);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit t;
        bus.en = 1'b1; bus.sec_tick = 1'b0; bus.side_car = 1'b0; bus.ped_req = 1'b0;

        // Reset and idle green extension
        do_reset();
        chk_state("reset", L_MG, MG);
        chk("reset_ack", int'(bus.ped_ack), 0);
        for (int k = 1; k <= 12; k++) begin
            ticks(1);
            chk("idle_cnt", int'(bus.cnt_out), 4 - (k % 4));
            chk("idle_side_red", int'(bus.side_red), 1);
        end

        // Side-road demand full cycle
        do_reset();
        bus.side_car = 1'b1;
        ticks(4);  chk_state("main_y", L_MY, YT);
`ifdef ALL_RED_CLEAR_EN
        ticks(2);  chk_state("ar_m", L_AR, ART);
        ticks(1);  chk_state("side_g", L_SG, SG);
        ticks(3);  chk_state("side_y", L_SY, YT);
        ticks(2);  chk_state("ar_s", L_AR, ART);
        ticks(1);  chk_state("main_g", L_MG, MG);
`else
        ticks(2);  chk_state("side_g", L_SG, SG);
        ticks(3);  chk_state("side_y", L_SY, YT);
        ticks(2);  chk_state("main_g", L_MG, MG);
`endif

        // Pedestrian pulse during main green
        do_reset();
        bus.side_car = 1'b0;
        bus.ped_req = 1'b1; step(t); bus.ped_req = 1'b0;
        ticks(4);  chk_state("ped_main_y", L_MY, YT);
        ticks(2 + ARX);
        chk_state("ped_walk", L_WK, WT);
        chk("ped_ack_entry", int'(bus.ped_ack), 1);
        step(t);
        chk("ped_ack_once", int'(bus.ped_ack), 0);
        ticks(3);  chk_state("ped_back", L_MG, MG);

        // Request on the deciding edge, then a request absorbed during walk
        do_reset();
        bus.side_car = 1'b1;
        ticks(5 + ARX);
        while (pc % 4 != 3) step(t);
        bus.ped_req = 1'b1; step(t); bus.ped_req = 1'b0;
        bus.side_car = 1'b0;
        chk_state("late_walk", L_WK, WT);
        chk("late_ack", int'(bus.ped_ack), 1);
        bus.ped_req = 1'b1; step(t); bus.ped_req = 1'b0;
        ticks(3);  chk_state("after_walk", L_MG, MG);
        ticks(4);  chk_state("no_second_walk", L_MG, MG);

        // Enable freeze mid side green, then reset mid side yellow
        do_reset();
        bus.side_car = 1'b1;
        ticks(7 + ARX);
        chk_state("pre_freeze", L_SG, 2);
        bus.en = 1'b0;
        repeat (10) step(t);
        chk_state("frozen", L_SG, 2);
        bus.en = 1'b1;
        ticks(2);  chk_state("resume_y", L_SY, YT);
        ticks(1);  chk_state("mid_y", L_SY, 1);
        rstb = 1'b1; @(posedge clk); #1; rstb = 1'b0; pc = 0;
        chk_state("mid_reset", L_MG, MG);
        chk("mid_reset_ack", int'(bus.ped_ack), 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) bus.side_car = $urandom_range(0, 1);
            bus.ped_req  = ($urandom_range(0, 19) == 0);
            bus.en       = ($urandom_range(0, 19) != 0);
            bus.sec_tick = ($urandom_range(0, 3) == 0);
            rstb         = ($urandom_range(0, 499) == 0);
            @(posedge clk); #1;
        end
        rstb = 1'b0; bus.sec_tick = 1'b0; bus.ped_req = 1'b0;
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/intersection_phase_scheduler.md
Name: intersection_phase_scheduler

Overview:
Sequences a two-approach intersection: main road, side road, and a pedestrian crossing. It is driven by the existing one-second tick and owns a single shared down-counter, so at most one approach is ever non-red. The block arbitrates the crossing between side-road demand and pedestrian requests, with a req/ack handshake for the pedestrian push-button. It sits in the same slot as the single-approach light controller; cnt_out feeds the existing two-digit display path unchanged.

Parameters:
MAIN_GREEN_TIME, 15, main-road green duration in seconds (>=1)
SIDE_GREEN_TIME, 10, side-road green duration in seconds (>=1)
YELLOW_TIME, 3, yellow duration in seconds, used by both approaches (>=1)
WALK_TIME, 8, pedestrian walk duration in seconds (>=1)
ALL_RED_TIME, 2, all-red clearance duration in seconds; used only with ALL_RED_CLEAR_EN (>=1)
pCount_Width, $clog2(max of all times + 1), counter and cnt_out width

Ports:
clk  in  1  system clock
rstb  in  1  reset; synchronous, active-high
en  in  1  global enable; 0 freezes state, counter and outputs
sec_tick  in  1  one-cycle pulse per second, from the second counter
side_car  in  1  side-road vehicle present (level)
ped_req  in  1  pedestrian request (level or pulse)
ped_ack  out  1  one-cycle pulse when a request is granted
main_red/main_yellow/main_green  out  1 each  main-road lamps, one-hot
side_red/side_yellow/side_green  out  1 each  side-road lamps, one-hot
walk  out  1  pedestrian walk lamp
cnt_out  out  pCount_Width  seconds remaining in the current phase

Behaviour:
- States: MAIN_G, MAIN_Y, SIDE_G, SIDE_Y, PED_WALK. With ALL_RED_CLEAR_EN, two more states are added: AR_M (after MAIN_Y) and AR_S (after SIDE_Y).
- Reset (rstb=1 at the clk edge): state=MAIN_G, cnt_out=MAIN_GREEN_TIME, ped_pend=0, ped_ack=0, walk=0. Lamps: main_green=1, side_red=1, all other lamps 0. Reset mid-phase aborts that phase immediately.
- Counter rule: on entering a state, cnt loads that state's time T. Each sec_tick with en=1 decrements cnt. A sec_tick while cnt==1 is the expiry: next state and its new T are loaded on that same edge. Each state therefore lasts exactly T ticks, and cnt_out never shows 0.
- en=0: ticks and state are held. ped_req is still latched into ped_pend.
- Transitions, all on expiry:
  MAIN_G -> MAIN_Y if side_car or ped_pend_eff; otherwise MAIN_G reloads MAIN_GREEN_TIME (green extension).
  MAIN_Y -> PED_WALK if ped_pend_eff, else SIDE_G. With the macro, MAIN_Y -> AR_M, and the same decision is made on AR_M expiry.
  SIDE_G -> SIDE_Y, always.
  SIDE_Y -> MAIN_G. With the macro, SIDE_Y -> AR_S -> MAIN_G.
  PED_WALK -> SIDE_G if side_car, else MAIN_G.
- ped_pend_eff = ped_pend | ped_req. A request arriving on the deciding edge counts.
- ped_pend is set by ped_req and cleared on the edge entering PED_WALK. ped_ack=1 for exactly that one cycle.
- ped_req asserted during PED_WALK is absorbed: it is not latched and produces no second walk.
- Lamps are a registered decode of state; no glitches.
  main_green=MAIN_G; main_yellow=MAIN_Y; main_red otherwise.
  side_green=SIDE_G; side_yellow=SIDE_Y; side_red otherwise.
  walk=PED_WALK.
- Invariant: main and side are never both non-red. walk=1 implies main_red and side_red.

Optional Feature:
ALL_RED_CLEAR_EN:
- Defined: AR_M and AR_S are inserted, each lasting ALL_RED_TIME ticks with both approaches red and walk=0.
- Undefined: those states and the ALL_RED_TIME logic are absent; yellow goes directly to the next green or walk.

Decomposition:
- Package traffic_pkg holds: state encoding localparams, a phase_time function (state -> T), and the max-time constant used to derive pCount_Width.
- One sub-module, phase_down_counter. Interface: load, load_val, tick, en, count, expire. Reusable by other light controllers.
- The FSM, request latch and lamp decode stay in the top module.

Test Plan:
Common settings: MAIN_GREEN_TIME=4, SIDE_GREEN_TIME=3, YELLOW_TIME=2, WALK_TIME=3; sec_tick every 4 cycles.
- Reset, then side_car=0 and ped_req=0 for 12 ticks -> stays MAIN_G; cnt_out sequence 4,3,2,1,4,...; side_red=1 throughout.
- side_car=1 held -> cycle MAIN_G(4 ticks), MAIN_Y(2), SIDE_G(3), SIDE_Y(2), MAIN_G; lamps one-hot per approach at every cycle.
- ped_req one-cycle pulse during MAIN_G with side_car=0 -> MAIN_Y, then PED_WALK; walk=1 for 3 ticks; ped_ack high exactly 1 cycle at entry; then MAIN_G.
- ped_req asserted on the same edge as MAIN_Y expiry -> PED_WALK is entered. A second ped_req during PED_WALK -> no second walk phase.
- en=0 for 10 cycles spanning 2 ticks mid-SIDE_G -> cnt_out and lamps frozen; the phase resumes with its remaining count. rstb=1 mid-SIDE_Y -> next cycle MAIN_G, cnt_out=4, ped_ack=0.
- With ALL_RED_CLEAR_EN and ALL_RED_TIME=1 -> one tick of all-red after each yellow. Assert no cycle has two non-red approaches.
